// File: rtl/video_out_sd.sv
// Final video output stage: 2-stage RGB/sync pipe, sigma-delta TV DACs, vsync-latched mode mux.
// Optional VIDEO_OUT_CVBS_PWM_EN: composite on RGB uses the CVBS modulator bit instead of the sample.
module video_out_sd #(
    parameter int IN_W            = 5,
    parameter int VGA_W           = 4,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic             clk_color_mod,
    input  logic             reset_n,
    input  logic [VGA_W-1:0] video_r,
    input  logic [VGA_W-1:0] video_g,
    input  logic [VGA_W-1:0] video_b,
    input  logic             vga_hs,
    input  logic             vga_vs,
    input  logic [IN_W-1:0]  tv_cvbs,
    input  logic [IN_W-1:0]  tv_luma,
    input  logic [IN_W-1:0]  tv_chroma,
    input  logic [1:0]       tv_mode,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic [VGA_W-1:0] VGA_R,
    output logic [VGA_W-1:0] VGA_G,
    output logic [VGA_W-1:0] VGA_B,
    output logic             S_VIDEO_Y,
    output logic             S_VIDEO_C,
    output logic             CVBS,
    output logic [1:0]       mode_active
);

    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        MODE_VGA   = 2'b00,
        MODE_CVBS  = 2'b01,
        MODE_SVID  = 2'b10,
        MODE_BLANK = 2'b11
    } mode_e;

    logic [VGA_W-1:0] s1_r;
    logic [VGA_W-1:0] s1_g;
    logic [VGA_W-1:0] s1_b;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_vs_prev;
    logic [IN_W-1:0]  s1_cvbs;
    logic [IN_W-1:0]  s1_luma;
    logic [IN_W-1:0]  s1_chroma;
    logic [1:0]       s1_tv_mode;

    logic [IN_W:0]    acc_cvbs;
    logic [IN_W:0]    acc_luma;
    logic [IN_W:0]    acc_chroma;

    logic [1:0]       mode_q;
    logic [1:0]       mode_sel;
    logic             vs_start;
    logic [VGA_W-1:0] cvbs_tv;
    logic [VGA_W-1:0] rgb_r;
    logic [VGA_W-1:0] rgb_g;
    logic [VGA_W-1:0] rgb_b;

    // Stage 1: input capture
    always_ff @(posedge clk_color_mod or negedge reset_n) begin
        if (!reset_n) begin
            s1_r       <= '0;
            s1_g       <= '0;
            s1_b       <= '0;
            s1_hs      <= SYNC_IDLE;
            s1_vs      <= SYNC_IDLE;
            s1_vs_prev <= SYNC_IDLE;
            s1_cvbs    <= '0;
            s1_luma    <= '0;
            s1_chroma  <= '0;
            s1_tv_mode <= '0;
        end else begin
            s1_r       <= video_r;
            s1_g       <= video_g;
            s1_b       <= video_b;
            s1_hs      <= vga_hs;
            s1_vs      <= vga_vs;
            s1_vs_prev <= s1_vs;
            s1_cvbs    <= tv_cvbs;
            s1_luma    <= tv_luma;
            s1_chroma  <= tv_chroma;
            s1_tv_mode <= tv_mode;
        end
    end

    // First-order modulators: carry out of the low IN_W bits is the DAC bit
    always_ff @(posedge clk_color_mod or negedge reset_n) begin
        if (!reset_n) begin
            acc_cvbs   <= '0;
            acc_luma   <= '0;
            acc_chroma <= '0;
        end else begin
            acc_cvbs   <= {1'b0, acc_cvbs[IN_W-1:0]} + {1'b0, s1_cvbs};
            acc_luma   <= {1'b0, acc_luma[IN_W-1:0]} + {1'b0, s1_luma};
            acc_chroma <= {1'b0, acc_chroma[IN_W-1:0]} + {1'b0, s1_chroma};
        end
    end

    always_comb begin
        vs_start = 1'b0;
        if (SYNC_IDLE)
            vs_start = s1_vs_prev & ~s1_vs;
        else
            vs_start = ~s1_vs_prev & s1_vs;
    end

    // The pixel aligned with the vsync edge already uses the new mode
    assign mode_sel = vs_start ? s1_tv_mode : mode_q;

`ifdef VIDEO_OUT_CVBS_PWM_EN
    assign cvbs_tv = {VGA_W{acc_cvbs[IN_W]}};
`else
    assign cvbs_tv = s1_cvbs[IN_W-1 -: VGA_W];
`endif

    always_comb begin
        rgb_r = '0;
        rgb_g = '0;
        rgb_b = '0;
        unique case (mode_e'(mode_sel))
            MODE_VGA: begin
                rgb_r = s1_r;
                rgb_g = s1_g;
                rgb_b = s1_b;
            end
            MODE_CVBS: begin
                rgb_r = cvbs_tv;
                rgb_g = cvbs_tv;
                rgb_b = cvbs_tv;
            end
            MODE_SVID: begin
                rgb_r = {VGA_W{acc_luma[IN_W]}};
                rgb_g = {VGA_W{acc_chroma[IN_W]}};
            end
            MODE_BLANK: begin
                rgb_r = '0;
            end
            default: begin
                rgb_r = '0;
            end
        endcase
    end

    // Stage 2: pin registers
    always_ff @(posedge clk_color_mod or negedge reset_n) begin
        if (!reset_n) begin
            VGA_HS    <= SYNC_IDLE;
            VGA_VS    <= SYNC_IDLE;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            S_VIDEO_Y <= 1'b0;
            S_VIDEO_C <= 1'b0;
            CVBS      <= 1'b0;
            mode_q    <= 2'b00;
        end else begin
            VGA_HS    <= s1_hs;
            VGA_VS    <= s1_vs;
            VGA_R     <= rgb_r;
            VGA_G     <= rgb_g;
            VGA_B     <= rgb_b;
            S_VIDEO_Y <= acc_luma[IN_W];
            S_VIDEO_C <= acc_chroma[IN_W];
            CVBS      <= acc_cvbs[IN_W];
            if (vs_start)
                mode_q <= s1_tv_mode;
        end
    end

    assign mode_active = mode_q;

endmodule

// File: tb/tb_video_out_sd.sv
// Randomized bench for video_out_sd against a history-based reference model.
// Model: pins at cycle j reflect inputs of cycle j-2; DAC bits from cumulative sample sums.
module tb_video_out_sd;

    localparam int IN_W  = 5;
    localparam int VGA_W = 4;
    localparam int N     = 32;
    localparam int HMAX  = 4096;

    localparam int F_R  = 0;
    localparam int F_G  = 1;
    localparam int F_B  = 2;
    localparam int F_HS = 3;
    localparam int F_VS = 4;
    localparam int F_C  = 5;
    localparam int F_Y  = 6;
    localparam int F_CH = 7;
    localparam int F_M  = 8;

    logic             clk_color_mod = 1'b0;
    logic             reset_n = 1'b0;
    logic [VGA_W-1:0] video_r = '0;
    logic [VGA_W-1:0] video_g = '0;
    logic [VGA_W-1:0] video_b = '0;
    logic             vga_hs = 1'b1;
    logic             vga_vs = 1'b1;
    logic [IN_W-1:0]  tv_cvbs = '0;
    logic [IN_W-1:0]  tv_luma = '0;
    logic [IN_W-1:0]  tv_chroma = '0;
    logic [1:0]       tv_mode = '0;
    logic             VGA_HS;
    logic             VGA_VS;
    logic [VGA_W-1:0] VGA_R;
    logic [VGA_W-1:0] VGA_G;
    logic [VGA_W-1:0] VGA_B;
    logic             S_VIDEO_Y;
    logic             S_VIDEO_C;
    logic             CVBS;
    logic [1:0]       mode_active;

    video_out_sd #(
        .IN_W(IN_W),
        .VGA_W(VGA_W),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk_color_mod(clk_color_mod),
        .reset_n(reset_n),
        .video_r(video_r),
        .video_g(video_g),
        .video_b(video_b),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .tv_cvbs(tv_cvbs),
        .tv_luma(tv_luma),
        .tv_chroma(tv_chroma),
        .tv_mode(tv_mode),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .S_VIDEO_Y(S_VIDEO_Y),
        .S_VIDEO_C(S_VIDEO_C),
        .CVBS(CVBS),
        .mode_active(mode_active)
    );

    always #5 clk_color_mod = ~clk_color_mod;

    int checks = 0;
    int errors = 0;
    int hist [0:8][0:HMAX-1];
    int cum  [0:2][0:HMAX-1];
    int j = 0;
    int mode_m = 0;
    int vs_left = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, j);
        end
    endtask

    function automatic int past(input int k, input int f);
        if (k < 0)
            return (f == F_HS || f == F_VS) ? 1 : 0;
        return hist[f][k];
    endfunction

    // DAC bit from the add of sample k: change of floor(running_sum / 2^IN_W)
    function automatic int carry(input int k, input int ch);
        int prv;
        if (k < 0)
            return 0;
        prv = (k > 0) ? cum[ch][k-1] : 0;
        return cum[ch][k] / N - prv / N;
    endfunction

    task automatic check_outputs();
        int cb;
        int y;
        int c;
        int er;
        int eg;
        int eb;
        if (past(j-3, F_VS) == 1 && past(j-2, F_VS) == 0)
            mode_m = past(j-2, F_M);
        cb = carry(j-3, 0);
        y  = carry(j-3, 1);
        c  = carry(j-3, 2);
        er = 0;
        eg = 0;
        eb = 0;
        case (mode_m)
            0: begin
                er = past(j-2, F_R);
                eg = past(j-2, F_G);
                eb = past(j-2, F_B);
            end
            1: begin
`ifdef VIDEO_OUT_CVBS_PWM_EN
                er = cb * 15;
`else
                er = past(j-2, F_C) / 2;
`endif
                eg = er;
                eb = er;
            end
            2: begin
                er = y * 15;
                eg = c * 15;
            end
            default: er = 0;
        endcase
        check_eq("hs", int'(VGA_HS), past(j-2, F_HS));
        check_eq("vs", int'(VGA_VS), past(j-2, F_VS));
        check_eq("r", int'(VGA_R), er);
        check_eq("g", int'(VGA_G), eg);
        check_eq("b", int'(VGA_B), eb);
        check_eq("cvbs", int'(CVBS), cb);
        check_eq("svid_y", int'(S_VIDEO_Y), y);
        check_eq("svid_c", int'(S_VIDEO_C), c);
        check_eq("mode", int'(mode_active), mode_m);
    endtask

    task automatic record();
        if (j >= HMAX) begin
            $display("FAIL history overflow got=%0d exp<%0d", j, HMAX);
            $fatal(1);
        end
        hist[F_R][j]  = int'(video_r);
        hist[F_G][j]  = int'(video_g);
        hist[F_B][j]  = int'(video_b);
        hist[F_HS][j] = int'(vga_hs);
        hist[F_VS][j] = int'(vga_vs);
        hist[F_C][j]  = int'(tv_cvbs);
        hist[F_Y][j]  = int'(tv_luma);
        hist[F_CH][j] = int'(tv_chroma);
        hist[F_M][j]  = int'(tv_mode);
        cum[0][j] = (j > 0 ? cum[0][j-1] : 0) + int'(tv_cvbs);
        cum[1][j] = (j > 0 ? cum[1][j-1] : 0) + int'(tv_luma);
        cum[2][j] = (j > 0 ? cum[2][j-1] : 0) + int'(tv_chroma);
    endtask

    task automatic step();
        check_outputs();
        record();
        j++;
        @(negedge clk_color_mod);
    endtask

    task automatic rand_cycles(input int n, input bit allow_vs, input bit mode_chg);
        for (int i = 0; i < n; i++) begin
            video_r   = 4'($urandom);
            video_g   = 4'($urandom);
            video_b   = 4'($urandom);
            tv_cvbs   = 5'($urandom);
            tv_luma   = 5'($urandom);
            tv_chroma = 5'($urandom);
            if ($urandom_range(0, 3) == 0)
                vga_hs = ~vga_hs;
            if (mode_chg && $urandom_range(0, 15) == 0)
                tv_mode = 2'($urandom);
            if (vs_left > 0) begin
                vga_vs = 1'b0;
                vs_left--;
            end else begin
                vga_vs = 1'b1;
                if (allow_vs && $urandom_range(0, 39) == 0)
                    vs_left = $urandom_range(1, 10);
            end
            step();
        end
    endtask

    task automatic vs_pulse(input int len);
        for (int i = 0; i < len; i++) begin
            vga_vs = 1'b0;
            step();
        end
        vga_vs = 1'b1;
        step();
    endtask

    task automatic reset_mid_frame();
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst_r", int'(VGA_R), 0);
        check_eq("rst_g", int'(VGA_G), 0);
        check_eq("rst_b", int'(VGA_B), 0);
        check_eq("rst_hs", int'(VGA_HS), 1);
        check_eq("rst_vs", int'(VGA_VS), 1);
        check_eq("rst_dac", int'({S_VIDEO_Y, S_VIDEO_C, CVBS}), 0);
        check_eq("rst_mode", int'(mode_active), 0);
        vga_vs = 1'b1;
        vs_left = 0;
        @(negedge clk_color_mod);
        reset_n = 1'b1;
        j = 0;
        mode_m = 0;
    endtask

    initial begin
        int cnt_y;
        int cnt_r;
        int vals [3];
        vals[0] = 0;
        vals[1] = 16;
        vals[2] = 31;

        repeat (3) @(negedge clk_color_mod);
        check_eq("init_hs", int'(VGA_HS), 1);
        check_eq("init_mode", int'(mode_active), 0);
        reset_n = 1'b1;

        // Latency: red step together with an hsync toggle
        repeat (3) step();
        video_r = 4'hA;
        vga_hs = 1'b0;
        repeat (4) step();

        // Mode request mid-frame is deferred to the vsync edge
        tv_mode = 2'b01;
        rand_cycles(30, 1'b0, 1'b0);
        check_eq("defer", int'(mode_active), 0);
        for (int i = 0; i < 10; i++) begin
            vga_vs = 1'b0;
            if (i == 3)
                tv_mode = 2'b10;
            step();
        end
        vga_vs = 1'b1;
        step();
        check_eq("latch_once", int'(mode_active), 1);
        rand_cycles(20, 1'b0, 1'b0);

        // Blank with syncs running
        tv_mode = 2'b11;
        vs_pulse(2);
        rand_cycles(20, 1'b0, 1'b0);

        // DAC density in S-video mode
        tv_mode = 2'b10;
        vs_pulse(1);
        tv_chroma = '0;
        for (int v = 0; v < 3; v++) begin
            tv_luma = 5'(vals[v]);
            repeat (4) step();
            cnt_y = 0;
            cnt_r = 0;
            for (int i = 0; i < N; i++) begin
                step();
                cnt_y += int'(S_VIDEO_Y);
                cnt_r += (VGA_R == 4'hF) ? 1 : 0;
            end
            check_eq("density_y", cnt_y, vals[v]);
            check_eq("density_r", cnt_r, vals[v]);
        end

        // Composite on RGB
        tv_mode = 2'b01;
        tv_cvbs = 5'b10110;
        vs_pulse(3);
        repeat (4) step();
`ifdef VIDEO_OUT_CVBS_PWM_EN
        check_eq("cvbs_rgb", int'(VGA_R), CVBS ? 15 : 0);
`else
        check_eq("cvbs_rgb", int'(VGA_R), 4'b1011);
`endif

        rand_cycles(1500, 1'b1, 1'b1);

        // Async reset mid-frame while in composite mode
        tv_mode = 2'b01;
        vs_pulse(2);
        rand_cycles(10, 1'b0, 1'b0);
        reset_mid_frame();
        tv_mode = 2'b10;
        rand_cycles(40, 1'b0, 1'b0);
        check_eq("post_rst_mode", int'(mode_active), 0);
        rand_cycles(600, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
